muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller for the EX stage of the 5-stage RISC-V pipeline, implementing all eight RV32M operations. It captures the M-extension operands when the instruction enters EX, runs a one-bit-per-cycle shift-add or restoring-divide datapath, and holds the front of the pipeline with a stall request until the result is ready. The stall request is ORed with the hazard unit's load-use stall into StallF/StallD, and also holds the E pipeline register. PCSrcE-driven flushes abort an operation in flight.

---
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Bundles the EX-stage signals that pass between the pipeline and the
//   iterative multiply/divide sequencer.
//   master : pipeline side. Drives MdValidE, Funct3E, SrcAE, SrcBE and FlushE.
//            Receives MdStall, Busy, MdResultE and MdDoneE.
//   slave  : sequencer side, with the directions reversed.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            MdValidE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            MdStall;
  logic            Busy;
  logic [XLEN-1:0] MdResultE;
  logic            MdDoneE;

  modport master (
    output MdValidE, Funct3E, SrcAE, SrcBE, FlushE,
    input  MdStall, Busy, MdResultE, MdDoneE
  );

  modport slave (
    input  MdValidE, Funct3E, SrcAE, SrcBE, FlushE,
    output MdStall, Busy, MdResultE, MdDoneE
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide controller for the EX stage.
//   Multiply uses shift-add and divide uses a restoring step. Each op
//   resolves one bit per cycle, so an op takes XLEN cycles in CALC.
//   Divide-by-zero and signed overflow skip CALC and go straight to DONE.
//   Ports:
//     clk, reset_n : clock (rising edge) and asynchronous active-low reset
//     md (slave)   : MdValidE/Funct3E/SrcAE/SrcBE/FlushE in,
//                    MdStall/Busy/MdResultE/MdDoneE out
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               reset_n,
  muldiv_sequencer_if.slave md
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        f3;
  logic              sign_a, sign_b, fast;
  logic [XLEN-1:0]   mag_a, mag_b;
  // Multiply: product high in [2X-1:X], multiplier shifting out of [X-1:0].
  // Divide: dividend shifts out of the MSB of [X-1:0] as quotient bits shift in.
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [5:0]        cnt;

  // ---- operand decode at capture ----
  logic            is_div, sgn_a_op, sgn_b_op, in_sa, in_sb;
  logic            div0, ovf, in_fast, start;
  logic [XLEN-1:0] in_ma, in_mb;

  always_comb begin
    is_div   = md.Funct3E[2];
    sgn_a_op = 1'b0;
    sgn_b_op = 1'b0;
    case (md.Funct3E)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a_op = 1'b1; sgn_b_op = 1'b1; end
      3'b010:                         sgn_a_op = 1'b1;   // MULHSU
      default: ;
    endcase
    in_sa   = sgn_a_op & md.SrcAE[XLEN-1];
    in_sb   = sgn_b_op & md.SrcBE[XLEN-1];
    in_ma   = in_sa ? -md.SrcAE : md.SrcAE;
    in_mb   = in_sb ? -md.SrcBE : md.SrcBE;
    div0    = (md.SrcBE == '0);
    ovf     = ~md.Funct3E[0] & (md.SrcAE == MIN_INT) & (md.SrcBE == '1);
    in_fast = is_div & (div0 | ovf);
    start   = (state == IDLE) & md.MdValidE & ~md.FlushE;
  end

  // ---- one iteration of the datapath ----
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shift, div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : '0)};
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = div_shift - {2'b00, mag_b};
    div_ge    = ~div_diff[XLEN+1];   // no borrow: divisor fits
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      f3     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      fast   <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3     <= md.Funct3E;
          sign_a <= in_sa;
          sign_b <= in_sb;
          mag_a  <= in_ma;
          mag_b  <= in_mb;
          fast   <= in_fast;
          cnt    <= '0;
          if (in_fast) begin
            // The final answers are loaded now. DONE passes them through
            // without sign correction.
            acc   <= {{XLEN{1'b0}}, (div0 ? {XLEN{1'b1}} : MIN_INT)};
            rem   <= {1'b0, (div0 ? md.SrcAE : '0)};
            state <= DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, (is_div ? in_ma : in_mb)};
            rem   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (md.FlushE) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
            if (f3[2]) begin
              rem             <= div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
              acc[XLEN-1:0]   <= {acc[XLEN-2:0], div_ge};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            if (cnt == 6'(XLEN-1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- sign correction and outputs ----
  logic              neg;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, res;

  always_comb begin
    neg    = sign_a ^ sign_b;
    prod_s = neg ? -acc : acc;
    quot_s = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (fast)       res = f3[1] ? rem[XLEN-1:0] : acc[XLEN-1:0];
    else if (f3[2]) res = f3[1] ? rem_s : quot_s;
    else            res = (f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  assign md.MdResultE = (state == DONE) ? res : '0;
  assign md.MdDoneE   = (state == DONE) & ~md.FlushE;
  assign md.Busy      = (state == CALC);
  // The flush term drops the stall in the cycle the flush arrives.
  assign md.MdStall   = reset_n & ~md.FlushE &
                        (((state == IDLE) & md.MdValidE & ~in_fast) | (state == CALC));

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  muldiv_sequencer_if #(.XLEN(XLEN)) md ();
  muldiv_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .md(md));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues an op at the next cycle. It holds MdValidE until the result
  // arrives, and checks the result, the latency and the stall in every cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int  lat = -1;
    bit  stall_ok = 1'b1;
    @(posedge clk); #1;
    md.MdValidE = 1'b1; md.Funct3E = f3; md.SrcAE = a; md.SrcBE = b; md.FlushE = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_idle"}, 64'(md.Busy), 64'd0);
      if (md.MdStall !== ((exp_lat > 1) && (c < exp_lat))) stall_ok = 1'b0;
      if (md.MdDoneE === 1'b1) begin
        lat = c;
        chk(tag, 64'(md.MdResultE), 64'(exp));
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
  endtask

  initial begin
    md.MdValidE = 1'b0; md.Funct3E = '0; md.SrcAE = '0; md.SrcBE = '0; md.FlushE = 1'b0;
    #3;
    chk("rst_busy",   64'(md.Busy),      64'd0);
    chk("rst_done",   64'(md.MdDoneE),   64'd0);
    chk("rst_result", 64'(md.MdResultE), 64'd0);
    chk("rst_stall",  64'(md.MdStall),   64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Iterative ops
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("mulh_n", 3'b001, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("mulh_m", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    // Fast-path ops
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("rem0_n", 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Flush in CALC at cycle 10, then a new MUL issued at cycle 11
    @(posedge clk); #1;
    md.MdValidE = 1'b1; md.Funct3E = 3'b100; md.SrcAE = 32'd100; md.SrcBE = 32'd7;
    repeat (10) @(posedge clk);
    #1 md.FlushE = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(md.MdStall), 64'd0);
    chk("flush_done",  64'(md.MdDoneE), 64'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // Flush while in DONE suppresses MdDoneE
    @(posedge clk); #1;
    md.MdValidE = 1'b1; md.Funct3E = 3'b101; md.SrcAE = 32'd5; md.SrcBE = 32'd0;
    @(posedge clk); #1 md.FlushE = 1'b1;
    @(negedge clk);
    chk("done_flush", 64'(md.MdDoneE), 64'd0);
    @(posedge clk); #1 md.FlushE = 1'b0; md.MdValidE = 1'b0;

    // Reset asserted mid-MUL
    @(posedge clk); #1;
    md.MdValidE = 1'b1; md.Funct3E = 3'b000; md.SrcAE = 32'd7; md.SrcBE = 32'd9;
    repeat (15) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",   64'(md.Busy),      64'd0);
    chk("mid_rst_stall",  64'(md.MdStall),   64'd0);
    chk("mid_rst_done",   64'(md.MdDoneE),   64'd0);
    chk("mid_rst_result", 64'(md.MdResultE), 64'd0);
    md.MdValidE = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy",  64'(md.Busy),    64'd0);
    chk("post_rst_stall", 64'(md.MdStall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
